// File: rtl/inv_key_schedule_serial_if.sv
// ---------------------------------------------------------------------------
// inv_key_schedule_serial_if
// Byte-serial handshake bundle for the AES-128 inverse key schedule.
//   in_valid / in_ready / in_byte  : round-NR key bytes into the block
//   out_valid / out_ready          : round-key byte stream out of the block
//   out_byte / out_round / out_last: byte, its round index, end-of-stream flag
//   busy                           : block is not idle
// modport slave  : the key schedule block
// modport master : the producer/consumer driving it
// ---------------------------------------------------------------------------
interface inv_key_schedule_serial_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic [3:0] out_round;
    logic       out_last;
    logic       busy;

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_byte, out_round, out_last, busy
    );

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_byte, out_round, out_last, busy
    );
endinterface

// File: rtl/inv_key_schedule_serial.sv
// ---------------------------------------------------------------------------
// inv_key_schedule_serial
// Byte-serial AES-128 inverse key schedule. Loads the round-NR key one byte
// per cycle, then emits round keys NR down to 0, one byte per accepted
// out_valid/out_ready handshake. Between rounds a 16-cycle step rewinds the
// key register in place, one byte per cycle, through a single forward S-box.
// Ports:
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset
//   bus   : handshake bundle (slave side), see inv_key_schedule_serial_if
// ---------------------------------------------------------------------------
module inv_key_schedule_serial #(
    parameter int         NR        = 10,
    parameter logic [7:0] RCON_LAST = 8'h36
) (
    input  logic                        clk,
    input  logic                        rstn,
    inv_key_schedule_serial_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [7:0] kr [16];
    logic [3:0] bc;
    logic [3:0] rd;
    logic [7:0] rcon;

    logic       in_ready_c;
    logic       out_valid_c;
    logic [7:0] out_byte_c;
    logic [3:0] out_round_c;
    logic       out_last_c;

    logic [3:0] upd_idx;
    logic [7:0] upd_val;
    logic [1:0] j;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box computed as inverse (a^254, 0 maps to 0) plus affine map,
    // so no 256-entry table is needed.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] inv;
        s   = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s   = gf_mul(s, s);
            inv = gf_mul(inv, s);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Step byte update. First 12 cycles rewind w3..w1 top-down so the word
    // below is still old; last 4 cycles rewind w0 from the already-rewound w3.
    always_comb begin
        upd_idx = 4'd0;
        upd_val = 8'h00;
        j       = bc[1:0];
        if (bc < 4'd12) begin
            upd_idx = 4'd15 - bc;
            upd_val = kr[4'd15 - bc] ^ kr[4'd11 - bc];
        end else begin
            upd_idx = {2'b00, j};
            upd_val = kr[{2'b00, j}] ^ sbox(kr[{2'b11, j + 2'd1}])
                      ^ ((j == 2'd0) ? rcon : 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_byte_c  = 8'h00;
        out_round_c = 4'd0;
        out_last_c  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nx = S_LOAD;
            end
            S_LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && bc == 4'd15) state_nx = S_EMIT;
            end
            S_EMIT: begin
                out_valid_c = 1'b1;
                out_byte_c  = kr[bc];
                out_round_c = rd;
                out_last_c  = (rd == 4'd0) && (bc == 4'd15);
                if (bus.out_ready && bc == 4'd15)
                    state_nx = (rd == 4'd0) ? S_DONE : S_STEP;
            end
            S_STEP: begin
                if (bc == 4'd15) state_nx = S_EMIT;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // bc wraps 15 -> 0 naturally, which is the reset value every phase needs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) kr[i] <= 8'h00;
            bc   <= 4'd0;
            rd   <= 4'd0;
            rcon <= RCON_LAST;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        kr[0] <= bus.in_byte;
                        bc    <= 4'd1;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        kr[bc] <= bus.in_byte;
                        bc     <= bc + 4'd1;
                        if (bc == 4'd15) begin
                            rd   <= 4'(NR);
                            rcon <= RCON_LAST;
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) bc <= bc + 4'd1;
                end
                S_STEP: begin
                    kr[upd_idx] <= upd_val;
                    bc          <= bc + 4'd1;
                    if (bc == 4'd15) begin
                        rd   <= rd - 4'd1;
                        // Divide by x in GF(2^8); 0x1B/x wraps back to 0x80.
                        rcon <= (rcon == 8'h1B) ? 8'h80 : (rcon >> 1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_byte  = out_byte_c;
    assign bus.out_round = out_round_c;
    assign bus.out_last  = out_last_c;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_inv_key_schedule_serial.sv
// ---------------------------------------------------------------------------
// tb_inv_key_schedule_serial
// Bench for the byte-serial AES-128 inverse key schedule. A word-level model
// (table S-box, Rcon table, standard inverse recurrence) produces the expected
// byte stream; one negedge process compares every valid output byte.
// ---------------------------------------------------------------------------
module tb_inv_key_schedule_serial;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    inv_key_schedule_serial_if ifc();

    inv_key_schedule_serial #(.NR(10), .RCON_LAST(8'h36)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (ifc)
    );

    typedef struct {
        logic [7:0] b;
        logic [3:0] r;
        logic       l;
    } exp_t;

    exp_t         q[$];
    int           checks   = 0;
    int           failures = 0;
    int           popped   = 0;
    bit           rand_rdy = 0;
    bit           post_load = 0;
    logic [7:0]   sb [256];
    logic [7:0]   rcon_tab [11];
    logic [127:0] rk_m [11];

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] x, int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // S-box built by walking generator 3 and its inverse, independent of any
    // field inversion.
    task automatic build_sbox();
        logic [7:0] p, qq;
        p  = 8'h01;
        qq = 8'h01;
        do begin
            p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            qq = qq ^ {qq[6:0], 1'b0};
            qq = qq ^ {qq[5:0], 2'b00};
            qq = qq ^ {qq[3:0], 4'h0};
            if (qq[7]) qq = qq ^ 8'h09;
            sb[p] = qq ^ rotl8(qq, 1) ^ rotl8(qq, 2) ^ rotl8(qq, 3) ^ rotl8(qq, 4) ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        rcon_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    endtask

    function automatic logic [31:0] subrot(logic [31:0] w);
        return {sb[w[23:16]], sb[w[15:8]], sb[w[7:0]], sb[w[31:24]]};
    endfunction

    // Round r-1 from round r: undo the forward recurrence word by word.
    task automatic model(input logic [127:0] k10);
        logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3;
        rk_m[10] = k10;
        {w0, w1, w2, w3} = k10;
        for (int r = 10; r >= 1; r--) begin
            p3 = w3 ^ w2;
            p2 = w2 ^ w1;
            p1 = w1 ^ w0;
            p0 = w0 ^ subrot(p3) ^ {rcon_tab[r], 24'h0};
            {w0, w1, w2, w3} = {p0, p1, p2, p3};
            rk_m[r-1] = {w0, w1, w2, w3};
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int r = 10; r >= 0; r--)
            for (int i = 0; i < 16; i++) begin
                e.b = rk_m[r][127-8*i -: 8];
                e.r = 4'(r);
                e.l = (r == 0) && (i == 15);
                q.push_back(e);
            end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (ifc.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1'b1, 1'b0);
                end else begin
                    chk("out_byte",  ifc.out_byte,  q[0].b);
                    chk("out_round", ifc.out_round, q[0].r);
                    chk("out_last",  ifc.out_last,  q[0].l);
                    if (ifc.out_ready) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
            if (post_load && ifc.busy) chk("in_ready_while_busy", ifc.in_ready, 1'b0);
        end
    end

    initial begin
        ifc.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ifc.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset(string tag);
        chk({tag, "_in_ready"},  ifc.in_ready,  1'b1);
        chk({tag, "_out_valid"}, ifc.out_valid, 1'b0);
        chk({tag, "_out_byte"},  ifc.out_byte,  8'h00);
        chk({tag, "_out_round"}, ifc.out_round, 4'd0);
        chk({tag, "_out_last"},  ifc.out_last,  1'b0);
        chk({tag, "_busy"},      ifc.busy,      1'b0);
    endtask

    task automatic load_key(input logic [127:0] k, input bit gaps);
        bit acc;
        for (int i = 0; i < 16; i++) begin
            if (gaps && (i % 5 == 3)) begin
                ifc.in_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            ifc.in_valid = 1'b1;
            ifc.in_byte  = k[127-8*i -: 8];
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk);
                acc = ifc.in_ready;
                @(posedge clk);
                #1;
            end
            if (!acc) chk("load_accept_timeout", 1'b0, 1'b1);
        end
        ifc.in_valid = 1'b0;
        post_load = 1'b1;
    endtask

    // Waits for busy to drop; n counts busy cycles from the first out_valid.
    task automatic wait_done(input bit garbage, output int n);
        bit started;
        started = 1'b0;
        n = 0;
        for (int c = 0; c < 4000; c++) begin
            if (garbage) begin
                ifc.in_valid = 1'($urandom_range(0, 1));
                ifc.in_byte  = 8'($urandom);
            end
            @(negedge clk);
            if (ifc.out_valid) started = 1'b1;
            if (started && ifc.busy) n++;
            if (!ifc.busy) begin
                ifc.in_valid = 1'b0;
                post_load = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        post_load = 1'b0;
        chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_key(input logic [127:0] k, input bit gaps, input bit garbage,
                           input bit rnd, output int n);
        rand_rdy = rnd;
        model(k);
        push_expected();
        load_key(k, gaps);
        chk("first_out_latency", ifc.out_valid, 1'b1);
        wait_done(garbage, n);
        chk("stream_drained", q.size(), 0);
        rand_rdy = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        logic [127:0] rk;
        ifc.in_valid = 1'b0;
        ifc.in_byte  = 8'h00;
        build_sbox();

        // Model pins against hand-known values.
        chk("sbox_00", sb[8'h00], 8'h63);
        chk("sbox_01", sb[8'h01], 8'h7c);
        chk("sbox_53", sb[8'h53], 8'hed);
        model(FIPS_K10);
        chk("model_rk9", rk_m[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("model_rk1", rk_m[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_rk0", rk_m[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        model(128'h0);
        chk("model_zero_rk9", rk_m[9], 128'h55636363_00000000_00000000_00000000);

        #12;
        chk_reset("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // FIPS key, continuous ready; then random ready; then input gaps with
        // junk in_valid while the block is busy.
        run_key(FIPS_K10, 1'b0, 1'b0, 1'b0, n);
        run_key(FIPS_K10, 1'b0, 1'b0, 1'b1, n);
        run_key(FIPS_K10, 1'b1, 1'b1, 1'b0, n);

        // Reset in the step after round 5, then a full clean run.
        model(FIPS_K10);
        push_expected();
        load_key(FIPS_K10, 1'b0);
        base = popped;
        for (int c = 0; c < 1000 && popped < base + 96; c++) @(negedge clk);
        chk("reached_round5_end", popped - base, 96);
        repeat (4) @(posedge clk);
        #3;
        chk("mid_step_out_valid", ifc.out_valid, 1'b0);
        chk("mid_step_busy", ifc.busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk_reset("async_reset");
        q.delete();
        post_load = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run_key(FIPS_K10, 1'b0, 1'b0, 1'b0, n);

        // All-zero key with cycle count (busy count includes the DONE cycle).
        run_key(128'h0, 1'b0, 1'b0, 1'b0, n);
        chk("emit_to_done_cycles", n - 1, 336);

        // Back-to-back random keys with junk inputs during busy.
        for (int k = 0; k < 3; k++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_key(rk, k[0], 1'b1, 1'b1, n);
        end
        chk_reset("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
